// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that merges several byte-stream requesters onto one
// UART transmit byte stream. An owner keeps the grant for a whole packet, ending at req_last.
// It also loses the grant after MAX_BURST bytes, so one long stream cannot starve the others.
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester byte available
//   req_data   requester i byte in bits [8i+7:8i]
//   req_last   per-requester last-byte-of-packet flag
//   req_ready  per-requester accept; only the current owner can see ready
//   tx_data    byte presented to the UART transmitter
//   tx_valid   tx_data holds a byte
//   tx_ready   transmitter accepts tx_data this cycle
//   grant_id   index of current owner, 0 when idle
//   busy       a grant is held
//   burst_cut  one-cycle pulse when a grant is released by the burst limit

module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned MAX_BURST = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [1:0]           grant_id,
  output logic                 busy,
  output logic                 burst_cut
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  localparam logic [7:0] BurstMax = 8'(MAX_BURST);
  localparam logic [1:0] LastIdx  = 2'(NUM_REQ - 1);

  state_e     state;
  logic [1:0] rr_ptr;
  logic [7:0] burst_cnt;

  logic       own_valid;
  logic       own_last;
  logic [7:0] own_data;
  logic       slot_free;
  logic       accept;
  logic       sel_found;
  logic [1:0] sel_idx;
  logic [2:0] scan_idx;
  logic [1:0] next_ptr;
  logic [7:0] cnt_inc;

  // Owner's request lines, selected by the current grant.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == 2'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[8*i +: 8];
      end
    end
  end

  // The output register can take a new byte when it is empty or being drained this cycle.
  assign slot_free = !tx_valid || tx_ready;
  assign accept    = (state == StLocked) && own_valid && slot_free;

  always_comb begin
    req_ready = '0;
    if (state == StLocked) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_id == 2'(i)) begin
          req_ready[i] = slot_free;
        end
      end
    end
  end

  // Round-robin scan: first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 2'd0;
    scan_idx  = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + 3'(k);
      if (scan_idx >= 3'(NUM_REQ)) begin
        scan_idx = scan_idx - 3'(NUM_REQ);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!sel_found && (scan_idx == 3'(i)) && req_valid[i]) begin
          sel_found = 1'b1;
          sel_idx   = 2'(i);
        end
      end
    end
  end

  assign next_ptr = (grant_id == LastIdx) ? 2'd0 : grant_id + 2'd1;
  assign cnt_inc  = (burst_cnt == BurstMax) ? burst_cnt : burst_cnt + 8'd1;
  assign busy     = (state == StLocked);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      rr_ptr    <= 2'd0;
      burst_cnt <= 8'd0;
      grant_id  <= 2'd0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      burst_cut <= 1'b0;
    end else begin
      burst_cut <= 1'b0;

      // Output register: load on accept, otherwise empty once the transmitter takes it.
      if (accept) begin
        tx_valid <= 1'b1;
        tx_data  <= own_data;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end

      unique case (state)
        StIdle: begin
          if (sel_found) begin
            state     <= StLocked;
            grant_id  <= sel_idx;
            burst_cnt <= 8'd0;
          end
        end
        StLocked: begin
          if (accept) begin
            burst_cnt <= cnt_inc;
            if (own_last || (cnt_inc == BurstMax)) begin
              state     <= StIdle;
              rr_ptr    <= next_ptr;
              grant_id  <= 2'd0;
              // A last byte landing exactly on the limit is an ordinary release.
              burst_cut <= !own_last;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed packets per requester feed a per-requester source queue.
// Expected tx bytes go into a scoreboard queue, and a monitor compares every transmitter transfer.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

  localparam int unsigned NumReq   = 3;
  localparam int unsigned MaxBurst = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_last;
  logic [2:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        burst_cut;

  int n_checks = 0;
  int n_fail   = 0;
  int cut_cnt  = 0;
  logic busy_prev = 1'b0;

  logic [7:0] exp_q[$];
  logic [8:0] src0[$];
  logic [8:0] src1[$];
  logic [8:0] src2[$];
  logic [1:0] grant_log[$];

  uart_tx_arbiter #(
    .NUM_REQ  (NumReq),
    .MAX_BURST(MaxBurst)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .grant_id (grant_id),
    .busy     (busy),
    .burst_cut(burst_cut)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int src_size(input int i);
    case (i)
      0:       return src0.size();
      1:       return src1.size();
      default: return src2.size();
    endcase
  endfunction

  function automatic logic [8:0] src_head(input int i);
    case (i)
      0:       return src0[0];
      1:       return src1[0];
      default: return src2[0];
    endcase
  endfunction

  task automatic src_pop(input int i);
    case (i)
      0:       void'(src0.pop_front());
      1:       void'(src1.pop_front());
      default: void'(src2.pop_front());
    endcase
  endtask

  task automatic push_src(input int i, input logic last, input logic [7:0] d);
    case (i)
      0:       src0.push_back({last, d});
      1:       src1.push_back({last, d});
      default: src2.push_back({last, d});
    endcase
  endtask

  // Queue one byte at requester i and record it as the next expected tx byte.
  task automatic send(input int i, input logic last, input logic [7:0] d);
    push_src(i, last, d);
    exp_q.push_back(d);
  endtask

  // seq holds 2-bit grant ids, first grant in the lowest bits.
  task automatic check_grants(input string name, input int n, input logic [15:0] seq);
    check({name, "_count"}, grant_log.size(), n);
    for (int k = 0; k < n && k < grant_log.size(); k++) begin
      check(name, grant_log[k], seq[2*k +: 2]);
    end
    grant_log.delete();
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || src0.size() != 0 || src1.size() != 0 || src2.size() != 0 ||
            tx_valid || busy) && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({name, "_bytes_left"}, exp_q.size(), 0);
  endtask

  // Requester drivers: pop the head once the handshake completed at the previous edge.
  initial begin
    logic [2:0] hs;
    logic [8:0] h;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (hs[i] && src_size(i) > 0) src_pop(i);
        if (src_size(i) > 0) begin
          h = src_head(i);
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = h[7:0];
          req_last[i]        = h[8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Monitor: score each transfer, count cut pulses and log each new grant.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_tx: got byte 0x%02h, required no transfer", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", tx_data, e);
        end
      end
      if (burst_cut) cut_cnt++;
      if (busy && !busy_prev) grant_log.push_back(grant_id);
      busy_prev = busy;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000ns, required to finish earlier");
    $fatal(1);
  end

  initial begin
    int k;
    int lat;
    int cut0;
    tx_ready = 1'b1;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_burst_cut", burst_cut, 0);
    check("rst_req_ready", req_ready, 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Single packet from requester 1, two cycles of latency, full rate after that.
    send(1, 1'b0, 8'h41);
    send(1, 1'b0, 8'h42);
    send(1, 1'b1, 8'h43);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!req_valid[1] && k < 5);
    lat = 0;
    while (!tx_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("first_byte_latency", lat, 2);
    @(negedge clk);
    check("tx_valid_byte2", tx_valid, 1);
    @(negedge clk);
    check("tx_valid_byte3", tx_valid, 1);
    check("busy_after_last", busy, 0);
    wait_drain("pkt1");

    // rr_ptr should now be 2: requester 2 wins over requester 0.
    send(2, 1'b1, 8'h21);
    send(0, 1'b1, 8'h01);
    wait_drain("rr_ptr");
    check_grants("grants_rr", 3, {2'd0, 2'd2, 2'd1});

    // Contention from reset: three 2-byte packets plus a second packet on requester 0.
    rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #2;
    grant_log.delete();
    send(0, 1'b0, 8'h01);
    send(0, 1'b1, 8'h02);
    push_src(1, 1'b0, 8'h11);
    push_src(1, 1'b1, 8'h12);
    push_src(2, 1'b0, 8'h21);
    push_src(2, 1'b1, 8'h22);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h21);
    exp_q.push_back(8'h22);
    send(0, 1'b0, 8'h03);
    send(0, 1'b1, 8'h04);
    wait_drain("contention");
    check_grants("grants_contention", 4, {2'd0, 2'd2, 2'd1, 2'd0});

    // Backpressure: hold 0x4F for five cycles with the transmitter stalled.
    tx_ready = 1'b0;
    send(2, 1'b0, 8'h4E);
    send(2, 1'b0, 8'h4F);
    send(2, 1'b1, 8'h50);
    k = 0;
    while (!tx_valid && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_tx_data", tx_data, 8'h4F);
      check("stall_tx_valid", tx_valid, 1);
      check("stall_req_ready", req_ready, 3'b000);
    end
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    wait_drain("backpressure");
    check_grants("grants_backpressure", 1, 16'(2'd2));

    // Burst cut: requester 0 streams six bytes, requester 2 is waiting.
    cut0 = cut_cnt;
    send(0, 1'b0, 8'hA1);
    send(0, 1'b0, 8'hA2);
    send(0, 1'b0, 8'hA3);
    send(0, 1'b0, 8'hA4);
    push_src(0, 1'b0, 8'hA5);
    push_src(0, 1'b1, 8'hA6);
    send(2, 1'b1, 8'hC1);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hA6);
    wait_drain("burst_cut");
    check("burst_cut_pulses", cut_cnt - cut0, 1);
    check_grants("grants_burst_cut", 3, {2'd0, 2'd2, 2'd0});

    // Last byte exactly at the burst limit: ordinary release, no cut.
    cut0 = cut_cnt;
    send(1, 1'b0, 8'hB1);
    send(1, 1'b0, 8'hB2);
    send(1, 1'b0, 8'hB3);
    send(1, 1'b1, 8'hB4);
    wait_drain("last_at_limit");
    check("last_at_limit_cut", cut_cnt - cut0, 0);
    check_grants("grants_last_at_limit", 1, 16'(2'd1));

    // Reset mid-packet while a byte sits stalled in the output register.
    tx_ready = 1'b0;
    push_src(1, 1'b0, 8'hD1);
    push_src(1, 1'b0, 8'hD2);
    push_src(1, 1'b1, 8'hD3);
    k = 0;
    while (!tx_valid && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("busy_before_reset", busy, 1);
    check("tx_valid_before_reset", tx_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_grant_id", grant_id, 0);
    check("midrst_req_ready", req_ready, 3'b000);
    src0.delete();
    src1.delete();
    src2.delete();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tx_ready = 1'b1;
    @(posedge clk);
    #2;
    grant_log.delete();
    send(0, 1'b1, 8'hE1);
    send(2, 1'b1, 8'hF1);
    wait_drain("after_reset");
    check_grants("grants_after_reset", 2, {2'd2, 2'd0});

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of byte-stream requesters (2..4).
REQ-002 SHALL have parameter MAX_BURST, default 64, maximum bytes one grant may hold before forced release (1..255).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester byte available.
REQ-006 SHALL have port req_data  input  8*NUM_REQ  requester i byte in bits [8i+7:8i].
REQ-007 SHALL have port req_last  input  NUM_REQ  byte is last of requester's packet.
REQ-008 SHALL have port req_ready  output  NUM_REQ  byte accepted when req_valid[i]&req_ready[i].
REQ-009 SHALL have port tx_data  output  8  byte to UART transmitter.
REQ-010 SHALL have port tx_valid  output  1  tx_data holds a byte.
REQ-011 SHALL have port tx_ready  input  1  transmitter accepts; transfer when tx_valid&tx_ready.
REQ-012 SHALL have port grant_id  output  2  index of current owner; 0 when idle.
REQ-013 SHALL have port busy  output  1  a grant is held.
REQ-014 SHALL have port burst_cut  output  1  one-cycle pulse on forced release.

Function
REQ-015 SHALL implement states IDLE and LOCKED; busy=1 only in LOCKED.
REQ-016 In IDLE, SHALL scan requesters starting at rr_ptr, wrapping modulo NUM_REQ, and select the first with req_valid=1.
REQ-017 On selection, SHALL enter LOCKED next cycle with grant_id=selected, burst count=0; no byte accepted in the arbitration cycle (req_ready=0 in IDLE).
REQ-018 In IDLE with no req_valid, SHALL remain IDLE, rr_ptr unchanged.
REQ-019 In LOCKED, req_ready[grant_id] SHALL be combinationally (!tx_valid | tx_ready); all other req_ready SHALL be 0.
REQ-020 An accepted byte SHALL appear on tx_data with tx_valid=1 on the next cycle (1-cycle latency); tx_data SHALL hold stable while tx_valid&!tx_ready.
REQ-021 tx_valid SHALL clear the cycle after a transfer unless a new byte is accepted in the same cycle (back-to-back at full rate).
REQ-022 Burst count SHALL increment per accepted byte, saturating at MAX_BURST.
REQ-023 Accepting a byte with req_last=1 SHALL return to IDLE next cycle and set rr_ptr=(grant_id+1) mod NUM_REQ.
REQ-024 Accepting byte number MAX_BURST with req_last=0 SHALL force IDLE next cycle, set rr_ptr=(grant_id+1) mod NUM_REQ, and pulse burst_cut for one cycle.
REQ-025 req_last=1 on byte MAX_BURST SHALL be a normal release; burst_cut SHALL stay 0.
REQ-026 Owner dropping req_valid mid-packet SHALL keep the grant indefinitely (no timeout); no other requester is served.
REQ-027 The byte in tx_data at release SHALL still be delivered; the next owner's bytes SHALL wait until tx_valid&tx_ready or tx_valid=0 per REQ-019.
REQ-028 Changes to req_data/req_last of non-owners SHALL have no effect.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, rr_ptr=0, burst count=0, tx_valid=0, tx_data=0, grant_id=0, busy=0, burst_cut=0, req_ready=0.
REQ-030 Reset mid-packet SHALL discard the held tx_data byte; after rst_n rises, first edge performs IDLE arbitration from rr_ptr=0.

Verification
REQ-031 Single packet: req 1 sends 0x41,0x42,0x43(last), tx_ready=1 -> tx_data 0x41,0x42,0x43 on consecutive cycles, first 2 cycles after req_valid, then IDLE, rr_ptr=2.
REQ-032 Contention: all 3 requesters valid with 2-byte packets from reset -> grant order 0,1,2,0; no byte interleaving within a packet.
REQ-033 Backpressure: tx_ready=0 for 5 cycles while tx_valid=1, tx_data=0x4F -> tx_data stays 0x4F, req_ready[owner]=0, no byte lost or duplicated.
REQ-034 Burst cut: MAX_BURST=4, req 0 streams 6 bytes no last, req 2 waiting -> 4 bytes sent, burst_cut pulses once, req 2 granted next, req 0 resumes after.
REQ-035 Last at limit: MAX_BURST=4, 4th byte last=1 -> release, burst_cut=0.
REQ-036 Reset mid-packet: rst_n low 1 cycle during LOCKED with tx_valid=1 -> tx_valid=0, busy=0 immediately; afterwards arbitration restarts at requester 0.
